// File: rtl/timer_interrupt_unit.sv
// Timer flag receiver: synchronises the timer's flag-write strobe, holds TIFR/TIMSK and runs the
// prioritised request/acknowledge/return handshake with the CPU.
module timer_interrupt_unit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       sysClock,
  input  logic       reset,
  input  logic       TIFR_write_enable,
  input  logic [7:0] TIFR_input,
  input  logic       cpu_write_TIFR,
  input  logic       cpu_write_TIMSK,
  input  logic [7:0] cpu_data,
  input  logic       SREG_I,
  input  logic       irq_ack,
  input  logic       irq_done,
  output logic [7:0] TIFR_output,
  output logic [7:0] TIMSK_output,
  output logic       irq_request,
  output logic [3:0] irq_vector
);

  localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {StIdle, StPending, StService} state_e;

  state_e            state_q, state_d;
  logic [Stages-1:0] sync_q;
  logic              edge_q;
  logic [7:0]        tifr_q, tifr_d;
  logic [7:0]        timsk_q, timsk_d;
  logic              req_q, req_d;
  logic [3:0]        vec_q, vec_d;

  logic       strobe_event;
  logic [7:0] pending;
  logic [3:0] sel_vec;
  logic [3:0] ack_off;
  logic [7:0] ack_mask;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;

  assign strobe_event = sync_q[Stages-1] & ~edge_q;
  assign pending      = tifr_q & timsk_q;
  assign set_mask     = strobe_event ? TIFR_input : 8'h00;

  // Highest set bit wins; bit i maps to vector 11-i.
  always_comb begin
    sel_vec = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) sel_vec = 4'(11 - i);
    end
  end

  always_comb begin
    ack_off  = 4'd11 - vec_q;
    ack_mask = 8'h00;
    if (vec_q >= 4'd4 && vec_q <= 4'd11) ack_mask[ack_off[2:0]] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    vec_d    = vec_q;
    clr_mask = cpu_write_TIFR ? cpu_data : 8'h00;
    unique case (state_q)
      StIdle: begin
        req_d = 1'b0;
        if (SREG_I && (pending != 8'h00)) begin
          state_d = StPending;
          req_d   = 1'b1;
          vec_d   = sel_vec;
        end
      end
      StPending: begin
        if ((pending == 8'h00) || !SREG_I) begin
          state_d = StIdle;
          req_d   = 1'b0;
        end else if (irq_ack) begin
          // Clear the bit behind the vector the CPU actually saw this cycle.
          clr_mask = clr_mask | ack_mask;
          state_d  = StService;
          req_d    = 1'b0;
        end else begin
          req_d = 1'b1;
          vec_d = sel_vec;
        end
      end
      StService: begin
        req_d = 1'b0;
        if (irq_done) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
    // Hardware set overrides any clear of the same bit.
    tifr_d  = (tifr_q & ~clr_mask) | set_mask;
    timsk_d = cpu_write_TIMSK ? cpu_data : timsk_q;
  end

  always_ff @(posedge sysClock) begin
    if (reset) begin
      state_q <= StIdle;
      sync_q  <= '0;
      edge_q  <= 1'b0;
      tifr_q  <= 8'h00;
      timsk_q <= 8'h00;
      req_q   <= 1'b0;
      vec_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[Stages-2:0], TIFR_write_enable};
      edge_q  <= sync_q[Stages-1];
      tifr_q  <= tifr_d;
      timsk_q <= timsk_d;
      req_q   <= req_d;
      vec_q   <= vec_d;
    end
  end

  assign TIFR_output  = tifr_q;
  assign TIMSK_output = timsk_q;
  assign irq_request  = req_q;
  assign irq_vector   = vec_q;

endmodule

// File: doc/timer_interrupt_unit.md
Name: timer_interrupt_unit

Overview:
- Receiving end of the timer flag interface: sits between timer_control_unit1 (and the 8-bit timers) and the CPU core.
- Synchronises each timer's TIFR_write_enable strobe from the count clock domain and latches the event bits into the architectural TIFR register.
- Holds TIMSK and supports CPU write-one-to-clear of TIFR.
- Arbitrates pending, enabled flags by ATmega32 vector priority and runs a request/acknowledge/return handshake with the CPU.

Parameters:
- SYNC_STAGES, 2, number of sysClock flops synchronising TIFR_write_enable (minimum 2).

Ports:
- sysClock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- TIFR_write_enable  input  1  flag-write strobe from timer; asynchronous to sysClock.
- TIFR_input  input  8  flag event bits from timer; stable while TIFR_write_enable is high.
- cpu_write_TIFR  input  1  CPU write strobe to TIFR.
- cpu_write_TIMSK  input  1  CPU write strobe to TIMSK.
- cpu_data  input  8  CPU write data.
- SREG_I  input  1  global interrupt enable.
- irq_ack  input  1  CPU accepts the current request.
- irq_done  input  1  CPU executed RETI.
- TIFR_output  output  8  current flag register.
- TIMSK_output  output  8  current mask register.
- irq_request  output  1  interrupt request to CPU.
- irq_vector  output  4  vector number of the request.

Behaviour:
- Reset (sync, on sysClock edge with reset=1): TIFR=0, TIMSK=0, irq_request=0, irq_vector=0, state=IDLE, synchroniser and edge flops=0. Reset overrides every other input, including mid-handshake.
- Strobe capture:
  - TIFR_write_enable passes through a SYNC_STAGES flop chain, then one edge-detect flop.
  - A strobe event is a synced 0->1 transition: one event per strobe, however long the strobe stays high.
  - On an event, TIFR |= TIFR_input.
  - Latency with SYNC_STAGES=2: strobe sampled high at edge N; flag visible after edge N+2.
- CPU writes:
  - cpu_write_TIMSK: TIMSK <= cpu_data.
  - cpu_write_TIFR: TIFR &= ~cpu_data (write-one-to-clear). Zero bits leave flags untouched.
- Per-bit priority within one cycle: a hardware set beats a CPU clear and beats an ack-clear of the same bit. Clears of other bits still apply in that cycle.
- Bit-to-vector map, priority highest first:
  - bit7 -> 4
  - bit6 -> 5
  - bit5 -> 6
  - bit4 -> 7
  - bit3 -> 8
  - bit2 -> 9
  - bit1 -> 10
  - bit0 -> 11
- pending = TIFR & TIMSK. The selected vector is that of the highest set bit of pending.
- FSM, registered, three states:
  - IDLE: irq_request=0. If SREG_I=1 and pending!=0, go to PENDING next edge, with irq_request=1 and irq_vector=selected vector.
  - PENDING:
    - irq_request=1. irq_vector re-evaluated every cycle, so a higher-priority arrival preempts before ack.
    - If pending becomes 0 or SREG_I=0: go to IDLE, irq_request=0, irq_vector holds its last value.
    - On irq_ack=1: clear the TIFR bit mapped to the irq_vector value presented that cycle, irq_request=0, go to SERVICE.
  - SERVICE:
    - irq_request=0; further flags accumulate in TIFR.
    - irq_done=1 returns to IDLE; a new request can assert on the following edge.
  - irq_ack in IDLE or SERVICE and irq_done outside SERVICE are ignored.
- Request latency: flag set at edge M, SREG_I=1, bit unmasked -> irq_request=1 after edge M+1.
- TIMSK changes act on pending in the same cycle. Masking while PENDING is handled by the pending==0 rule.
- All 8 bits are independent. Simultaneous events in multiple bits all latch in one cycle.

Test Plan:
- Reset, TIMSK=0x10, SREG_I=1; TIFR_input=0x10 with strobe held high 20 cycles -> TIFR=0x10 after 3 edges, exactly one set event; irq_request=1 one edge later, irq_vector=7.
- Continue from PENDING: pulse irq_ack -> TIFR=0x00, irq_request=0, SERVICE; new 0x10 strobe sets TIFR but no request until irq_done, then request after the next edge.
- TIMSK=0xFF, event 0x01 then, before ack, event 0x80 -> irq_vector changes 11->4; ack clears only bit7; after irq_done, request again with vector 11.
- TIFR=0x11, cpu_write_TIFR=0x01 in the same cycle as a synced strobe with TIFR_input=0x01 -> TIFR stays 0x11 (set wins); with no strobe -> TIFR=0x10.
- SREG_I=0 with pending=0x04 -> no request; raise SREG_I -> irq_request next edge, vector 9; drop SREG_I while PENDING -> IDLE, flag kept.
- Assert reset during PENDING with TIFR=0x41, TIMSK=0x41 -> all outputs 0 next edge; strobe in progress during reset produces no flag.
